// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT frame sequencer: FSM state encoding,
// ceil-log2 for counter sizing, and address bit reversal for natural-order write-back.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int BITREV_MAX_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[4'(w - 1 - i)] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Control, sample-RAM, core and result-RAM signals of the frame sequencer.
// master = the sequencer, slave = the CPU/RAM/core environment around it.
interface fft_frame_sequencer_if
  import fft_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
);
  logic              start;
  logic              inverse;
  logic              busy;
  logic              done;
  logic              timeout_err;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [WIDTH-1:0]  mem_rd_real;
  logic [WIDTH-1:0]  mem_rd_imag;

  logic              core_inv;
  logic              core_in_en;
  logic [WIDTH-1:0]  core_in_real;
  logic [WIDTH-1:0]  core_in_imag;
  logic              core_out_en;
  logic [WIDTH-1:0]  core_out_real;
  logic [WIDTH-1:0]  core_out_imag;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [WIDTH-1:0]  mem_wr_real;
  logic [WIDTH-1:0]  mem_wr_imag;

  modport master (
    input  start, inverse,
    output busy, done, timeout_err,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_real, mem_rd_imag,
    output core_inv, core_in_en, core_in_real, core_in_imag,
    input  core_out_en, core_out_real, core_out_imag,
    output mem_wr_en, mem_wr_addr, mem_wr_real, mem_wr_imag
  );

  modport slave (
    output start, inverse,
    input  busy, done, timeout_err,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_real, mem_rd_imag,
    input  core_inv, core_in_en, core_in_real, core_in_imag,
    output core_out_en, core_out_real, core_out_imag,
    input  mem_wr_en, mem_wr_addr, mem_wr_real, mem_wr_imag
  );

endinterface

// File: rtl/fft_seq_timeout.sv
// Drain watchdog: load arms a TIMEOUT-cycle window, expire pulses on its last cycle.
// Dropping en disarms and clears the counter; no backpressure.
module fft_seq_timeout
  import fft_seq_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // Loaded on the last-input cycle with TIMEOUT-1, so the count reads 1 on
  // the cycle TIMEOUT-1 after load and the error state lands exactly TIMEOUT later.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!en) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (load) begin
      cnt_d   = CW'(TIMEOUT - 1);
      armed_d = 1'b1;
    end else if (armed_q && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = en && armed_q && !load && (cnt_q == CW'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the SDF FFT/IFFT core: reads N samples, feeds the core, writes N results back.
// Write-back is 1 cycle behind core_out_en; no backpressure. FFT_SEQ_BITREV_EN bit-reverses write addresses.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int N       = 64,
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  fft_frame_sequencer_if.master bus
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rd_cnt_q,  rd_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q,  wr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_real_q, wr_real_d;
  logic [WIDTH-1:0]  wr_imag_q, wr_imag_d;
  logic              wr_vld_q,  wr_vld_d;
  logic              rd_en_dly_q, rd_en_dly_d;
  logic              core_inv_q, core_inv_d;
  logic              tmo_err_q,  tmo_err_d;

  logic feeding;
  logic draining;
  logic accept_start;
  logic wr_accept;
  logic wr_last;
  logic tmo_load;
  logic tmo_expire;

  always_comb begin
    feeding      = (state_q == ST_FEED);
    draining     = (state_q == ST_DRAIN);
    accept_start = (state_q == ST_IDLE) && bus.start;
    // A write landing on the expiry cycle is dropped so ERR never coexists with a write.
    wr_accept    = (feeding || draining) && bus.core_out_en && !tmo_expire;
    wr_last      = wr_accept && (wr_cnt_q == ADDR_W'(N - 1));
    tmo_load     = draining && rd_en_dly_q;
  end

  fft_seq_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmo_load),
    .en      (draining),
    .expire  (tmo_expire)
  );

`ifdef FFT_SEQ_BITREV_EN
  logic [BITREV_MAX_W-1:0] wr_cnt_rev;
  assign wr_cnt_rev = bitrev(BITREV_MAX_W'(wr_cnt_q), ADDR_W);
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FEED;
      ST_FEED: begin
        if (wr_last)                                state_d = ST_DONE;
        else if (rd_cnt_q == ADDR_W'(N - 1))        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr_last)         state_d = ST_DONE;
        else if (tmo_expire) state_d = ST_ERR;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters, mode latch, sticky error and write-back register
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_real_d   = wr_real_q;
    wr_imag_d   = wr_imag_q;
    wr_vld_d    = wr_accept;
    rd_en_dly_d = feeding;
    core_inv_d  = core_inv_q;
    tmo_err_d   = tmo_err_q;

    if (accept_start) begin
      core_inv_d = bus.inverse;
      tmo_err_d  = 1'b0;
      rd_cnt_d   = '0;
      wr_cnt_d   = '0;
    end

    if (feeding) rd_cnt_d = rd_cnt_q + 1'b1;

    if (wr_accept) begin
      wr_cnt_d  = wr_cnt_q + 1'b1;
`ifdef FFT_SEQ_BITREV_EN
      wr_addr_d = wr_cnt_rev[ADDR_W-1:0];
`else
      wr_addr_d = wr_cnt_q;
`endif
      wr_real_d = bus.core_out_real;
      wr_imag_d = bus.core_out_imag;
    end

    if (tmo_expire) tmo_err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      wr_addr_q   <= '0;
      wr_real_q   <= '0;
      wr_imag_q   <= '0;
      wr_vld_q    <= 1'b0;
      rd_en_dly_q <= 1'b0;
      core_inv_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_real_q   <= wr_real_d;
      wr_imag_q   <= wr_imag_d;
      wr_vld_q    <= wr_vld_d;
      rd_en_dly_q <= rd_en_dly_d;
      core_inv_q  <= core_inv_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  // Outputs; core input data is gated so it reads zero outside valid cycles.
  always_comb begin
    bus.busy         = feeding || draining || (state_q == ST_DONE);
    bus.done         = (state_q == ST_DONE);
    bus.timeout_err  = tmo_err_q;
    bus.mem_rd_en    = feeding;
    bus.mem_rd_addr  = rd_cnt_q;
    bus.core_inv     = core_inv_q;
    bus.core_in_en   = rd_en_dly_q;
    bus.core_in_real = rd_en_dly_q ? bus.mem_rd_real : {WIDTH{1'b0}};
    bus.core_in_imag = rd_en_dly_q ? bus.mem_rd_imag : {WIDTH{1'b0}};
    bus.mem_wr_en    = wr_vld_q;
    bus.mem_wr_addr  = wr_addr_q;
    bus.mem_wr_real  = wr_real_q;
    bus.mem_wr_imag  = wr_imag_q;
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a RAM model and a 10-cycle stub core (real+5, ~imag).
// Build with FFT_SEQ_BITREV_EN defined to expect bit-reversed write addresses.
module tb_fft_frame_sequencer;

  localparam int N   = 64;
  localparam int W   = 16;
  localparam int AW  = 6;
  localparam int TMO = 1024;
  localparam int LAT = 10;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fft_frame_sequencer_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  fft_frame_sequencer #(.N(N), .WIDTH(W), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Sample RAM: 1-cycle read latency
  logic [W-1:0] ram_real [N];
  logic [W-1:0] ram_imag [N];
  always @(posedge clock) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_real <= ram_real[bus.mem_rd_addr];
      bus.mem_rd_imag <= ram_imag[bus.mem_rd_addr];
    end
  end

  // Stub core; stub_limit caps the number of samples it passes per frame
  logic [LAT-1:0] pv;
  logic [W-1:0]   pr [LAT];
  logic [W-1:0]   pi [LAT];
  int             stub_cnt;
  int             stub_limit = N;
  logic           inj_en = 1'b0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pv       <= '0;
      stub_cnt <= 0;
    end else begin
      pv <= {pv[LAT-2:0], bus.core_in_en && (stub_cnt < stub_limit)};
      if (!bus.busy)          stub_cnt <= 0;
      else if (bus.core_in_en) stub_cnt <= stub_cnt + 1;
    end
  end
  always @(posedge clock) begin
    pr[0] <= bus.core_in_real + 16'd5;
    pi[0] <= ~bus.core_in_imag;
    for (int i = 1; i < LAT; i++) begin
      pr[i] <= pr[i-1];
      pi[i] <= pi[i-1];
    end
  end
  assign bus.core_out_en   = pv[LAT-1] | inj_en;
  assign bus.core_out_real = pr[LAT-1];
  assign bus.core_out_imag = pi[LAT-1];

  logic [82:0] outs;
  assign outs = {bus.busy, bus.done, bus.timeout_err, bus.mem_rd_en, bus.mem_rd_addr,
                 bus.core_inv, bus.core_in_en, bus.core_in_real, bus.core_in_imag,
                 bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_real, bus.mem_wr_imag};

  // Monitor, sampled on the falling edge
  int   cyc = 0, rd_n, wr_n, done_n, busy_n, rd_first_cyc, last_in_cyc, done_cyc, tmo_cyc, inv_bad;
  bit   done_busy, tmo_seen, tmo_busy, exp_inv;
  logic [AW-1:0] rd_log [256];
  logic [AW-1:0] wr_addr_log [256];
  logic [W-1:0]  wr_real_log [256];
  logic [W-1:0]  wr_imag_log [256];

  always begin
    @(negedge clock);
    cyc = cyc + 1;
    if (bus.mem_rd_en) begin
      if (rd_n == 0) rd_first_cyc = cyc;
      if (rd_n < 256) rd_log[rd_n] = bus.mem_rd_addr;
      rd_n = rd_n + 1;
    end
    if (bus.core_in_en) last_in_cyc = cyc;
    if (bus.mem_wr_en) begin
      if (wr_n < 256) begin
        wr_addr_log[wr_n] = bus.mem_wr_addr;
        wr_real_log[wr_n] = bus.mem_wr_real;
        wr_imag_log[wr_n] = bus.mem_wr_imag;
      end
      wr_n = wr_n + 1;
    end
    if (bus.done) begin
      done_n    = done_n + 1;
      done_cyc  = cyc;
      done_busy = bus.busy;
    end
    if (bus.busy) busy_n = busy_n + 1;
    if (bus.busy && bus.core_inv !== exp_inv) inv_bad = inv_bad + 1;
    if (bus.timeout_err && !tmo_seen) begin
      tmo_seen = 1'b1;
      tmo_cyc  = cyc;
      tmo_busy = bus.busy;
    end
  end

  task automatic clear_logs();
    rd_n = 0; wr_n = 0; done_n = 0; busy_n = 0; inv_bad = 0;
    rd_first_cyc = 0; last_in_cyc = 0; done_cyc = 0; tmo_cyc = 0;
    done_busy = 1'b0; tmo_seen = 1'b0; tmo_busy = 1'b0;
  endtask

  function automatic logic [AW-1:0] exp_addr(input int k);
    logic [AW-1:0] a;
    a = AW'(k);
`ifdef FFT_SEQ_BITREV_EN
    return {a[0], a[1], a[2], a[3], a[4], a[5]};
`else
    return a;
`endif
  endfunction

  function automatic int rd_mismatches();
    int m = 0;
    for (int i = 0; i < rd_n && i < 256; i++)
      if (rd_log[i] !== AW'(i % N)) m++;
    return m;
  endfunction

  function automatic int wr_mismatches();
    int m = 0;
    for (int i = 0; i < wr_n && i < 256; i++) begin
      int k = i % N;
      logic [W-1:0] er = ram_real[k] + 16'd5;
      logic [W-1:0] ei = ~ram_imag[k];
      if (wr_addr_log[i] !== exp_addr(k) || wr_real_log[i] !== er || wr_imag_log[i] !== ei) m++;
    end
    return m;
  endfunction

  task automatic load_impulse();
    for (int i = 0; i < N; i++) begin
      ram_real[i] = (i == 0) ? 16'd1 : 16'd0;
      ram_imag[i] = 16'd0;
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < N; i++) begin
      ram_real[i] = 16'(i * 257 + 3);
      ram_imag[i] = 16'(16'hA000 - i * 7);
    end
  endtask

  task automatic do_start(input bit inv);
    @(posedge clock); #1;
    exp_inv = inv;
    bus.inverse = inv;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_end: busy still 1 after %0d cycles, required 0", budget);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.inverse = 1'b0;
    clear_logs();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL idle_outputs: got %h required 0", outs); end
  endtask

  task automatic test_basic();
    load_impulse();
    clear_logs();
    do_start(1'b0);
    wait_end(300);
    checks++; if (rd_n !== N) begin errors++; $display("FAIL basic_rd_count: got %0d required %0d", rd_n, N); end
    checks++; if (rd_mismatches() !== 0) begin errors++; $display("FAIL basic_rd_order: got %0d bad addrs required 0", rd_mismatches()); end
    checks++; if (wr_n !== N) begin errors++; $display("FAIL basic_wr_count: got %0d required %0d", wr_n, N); end
    checks++; if (wr_mismatches() !== 0) begin errors++; $display("FAIL basic_wr_data: got %0d bad writes required 0", wr_mismatches()); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_n); end
    checks++; if (busy_n !== N + LAT + 2) begin errors++; $display("FAIL basic_busy_cycles: got %0d required %0d", busy_n, N + LAT + 2); end
    checks++; if (done_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_on_done: got %0b required 1", done_busy); end
    checks++; if (done_cyc - rd_first_cyc !== N + LAT + 1) begin errors++; $display("FAIL basic_latency: got %0d required %0d", done_cyc - rd_first_cyc, N + LAT + 1); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL basic_timeout_err: got %0b required 0", bus.timeout_err); end
  endtask

  task automatic test_inverse();
    load_pattern();
    clear_logs();
    do_start(1'b1);
    checks++; if (bus.core_inv !== 1'b1) begin errors++; $display("FAIL inv_latched: got %0b required 1", bus.core_inv); end
    repeat (5) @(posedge clock);
    #1 bus.inverse = 1'b0;
    repeat (20) @(posedge clock);
    #1 bus.inverse = 1'b1;
    repeat (10) @(posedge clock);
    #1 bus.inverse = 1'b0;
    wait_end(300);
    checks++; if (inv_bad !== 0) begin errors++; $display("FAIL inv_stable: got %0d busy cycles with wrong core_inv required 0", inv_bad); end
    checks++; if (bus.core_inv !== 1'b1) begin errors++; $display("FAIL inv_held: got %0b required 1", bus.core_inv); end
    checks++; if (done_n !== 1 || wr_mismatches() !== 0) begin errors++; $display("FAIL inv_frame: got done=%0d bad=%0d required 1/0", done_n, wr_mismatches()); end
  endtask

  task automatic test_start_ignored();
    bit got = 1'b0;
    load_pattern();
    clear_logs();
    do_start(1'b0);
    repeat (9) @(posedge clock);
    #1 bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (58) @(posedge clock);
    #1 bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (bus.done) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL b2b_done_seen: got 0 required 1"); end
    bus.start = 1'b1;
    @(posedge clock); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_on_done: busy got %0b required 0", bus.busy); end
    checks++; if (rd_n !== N || done_n !== 1) begin errors++; $display("FAIL extra_starts: got rd=%0d done=%0d required %0d/1", rd_n, done_n, N); end
    @(posedge clock); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_after_done: busy got %0b required 1", bus.busy); end
    wait_end(300);
    checks++; if (rd_n !== 2 * N || rd_mismatches() !== 0) begin errors++; $display("FAIL b2b_reads: got rd=%0d bad=%0d required %0d/0", rd_n, rd_mismatches(), 2 * N); end
    checks++; if (done_n !== 2 || wr_n !== 2 * N || wr_mismatches() !== 0) begin errors++; $display("FAIL b2b_writes: got done=%0d wr=%0d bad=%0d required 2/%0d/0", done_n, wr_n, wr_mismatches(), 2 * N); end
  endtask

  task automatic test_timeout();
    int w0;
    load_pattern();
    clear_logs();
    stub_limit = N - 1;
    do_start(1'b0);
    wait_end(TMO + 300);
    checks++; if (!tmo_seen || tmo_cyc - last_in_cyc !== TMO) begin errors++; $display("FAIL tmo_timing: got seen=%0b delta=%0d required 1/%0d", tmo_seen, tmo_cyc - last_in_cyc, TMO); end
    checks++; if (tmo_busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %0b required 0", tmo_busy); end
    checks++; if (done_n !== 0 || wr_n !== N - 1) begin errors++; $display("FAIL tmo_frame: got done=%0d wr=%0d required 0/%0d", done_n, wr_n, N - 1); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %0b required 1", bus.timeout_err); end
    w0 = wr_n;
    bus_inject();
    checks++; if (wr_n !== w0) begin errors++; $display("FAIL idle_core_out: got %0d writes required %0d", wr_n, w0); end
    stub_limit = N;
    clear_logs();
    do_start(1'b0);
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %0b required 0", bus.timeout_err); end
    wait_end(300);
    checks++; if (done_n !== 1 || wr_mismatches() !== 0) begin errors++; $display("FAIL tmo_recover: got done=%0d bad=%0d required 1/0", done_n, wr_mismatches()); end
  endtask

  task automatic bus_inject();
    inj_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 inj_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_midframe();
    bit got = 1'b0;
    load_pattern();
    do_start(1'b1);
    for (int i = 0; i < 100; i++) begin
      if (bus.mem_rd_en && bus.mem_rd_addr == AW'(20)) begin got = 1'b1; break; end
      @(posedge clock); #1;
    end
    checks++; if (!got) begin errors++; $display("FAIL rst_reach_20: got 0 required 1"); end
    clear_logs();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (outs !== '0) begin errors++; $display("FAIL rst_async_outputs: got %h required 0", outs); end
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (done_n !== 0 || outs !== '0) begin errors++; $display("FAIL rst_no_done: got done=%0d outs=%h required 0/0", done_n, outs); end
    clear_logs();
    do_start(1'b0);
    wait_end(300);
    checks++; if (rd_n !== N || rd_mismatches() !== 0 || wr_n !== N || wr_mismatches() !== 0 || done_n !== 1) begin
      errors++; $display("FAIL rst_clean_frame: got rd=%0d wr=%0d bad=%0d done=%0d required %0d/%0d/0/1", rd_n, wr_n, wr_mismatches(), done_n, N, N);
    end
  endtask

  task automatic test_addr_order();
    logic [AW-1:0] e1, e2, e3;
`ifdef FFT_SEQ_BITREV_EN
    e1 = 6'd32; e2 = 6'd16; e3 = 6'd48;
`else
    e1 = 6'd1;  e2 = 6'd2;  e3 = 6'd3;
`endif
    load_pattern();
    clear_logs();
    do_start(1'b0);
    wait_end(300);
    checks++; if (wr_addr_log[0] !== 6'd0 || wr_addr_log[1] !== e1 || wr_addr_log[2] !== e2 || wr_addr_log[3] !== e3) begin
      errors++; $display("FAIL wr_addr_order: got %0d,%0d,%0d,%0d required 0,%0d,%0d,%0d",
                         wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3], e1, e2, e3);
    end
    checks++; if (wr_addr_log[N-1] !== exp_addr(N - 1)) begin errors++; $display("FAIL wr_addr_last: got %0d required %0d", wr_addr_log[N-1], exp_addr(N - 1)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverse();
    test_start_ignored();
    test_timeout();
    test_reset_midframe();
    test_addr_order();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
